// File: rtl/memlcd_pkg.sv
// Shared types and default timing for the memory-LCD frame sequencer.
package memlcd_pkg;

  localparam int unsigned RgbW          = 6;
  localparam int unsigned DefHActive    = 120;
  localparam int unsigned DefVLines     = 240;
  localparam int unsigned DefClkDiv     = 4;
  localparam int unsigned DefGenTicks   = 2;
  localparam int unsigned DefVcomHalf   = 1000000;

  typedef enum logic [2:0] {
    StIdle,
    StGstart,
    StShift,
    StGen,
    StFrameEnd
  } seq_state_e;

endpackage

// File: rtl/memlcd_frame_sequencer_if.sv
// FWFT pixel FIFO read port between the async FIFO and the frame sequencer.
interface memlcd_frame_sequencer_if;

  logic                          rempty;
  logic                          rd_en;
  logic [memlcd_pkg::RgbW-1:0]   rd_data;

  // master: sequencer (pops); slave: FIFO (supplies head word)
  modport master (input rempty, input rd_data, output rd_en);
  modport slave  (output rempty, output rd_data, input rd_en);

endinterface

// File: rtl/memlcd_vcom_gen.sv
// Free-running VCOM polarity generator; runs regardless of frame activity.
module memlcd_vcom_gen
  import memlcd_pkg::*;
#(
  parameter int unsigned VCOM_HALF = DefVcomHalf
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_va,
  output logic o_vb,
  output logic o_vcom
);

  localparam int unsigned CntW = (VCOM_HALF > 1) ? $clog2(VCOM_HALF) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(VCOM_HALF - 1);

  logic [CntW-1:0] cnt_q;
  logic            vcom_q, va_q, vb_q;
  logic            flip;

  assign flip = (cnt_q == CntLast);

  // Half-period counter and the three polarity registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q  <= '0;
      vcom_q <= 1'b0;
      va_q   <= 1'b0;
      vb_q   <= 1'b1;
    end else begin
      cnt_q <= flip ? '0 : cnt_q + 1'b1;
      if (flip) begin
        vcom_q <= ~vcom_q;
        va_q   <= ~vcom_q;
        vb_q   <= vcom_q;
      end
    end
  end

  assign o_vcom = vcom_q;
  assign o_va   = va_q;
  assign o_vb   = vb_q;

endmodule

// File: rtl/memlcd_frame_sequencer.sv
// Memory-LCD frame scheduler: drains the pixel FIFO and generates gate/source timing.
// Build option: MEMLCD_UNDERRUN_BLANK_EN - an empty FIFO at a pixel tick emits a blank
// pixel instead of stalling, keeping frame timing exact.
module memlcd_frame_sequencer
  import memlcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DefHActive,
  parameter int unsigned V_LINES   = DefVLines,
  parameter int unsigned CLK_DIV   = DefClkDiv,
  parameter int unsigned GEN_TICKS = DefGenTicks,
  parameter int unsigned VCOM_HALF = DefVcomHalf
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic                     o_underrun,
  memlcd_frame_sequencer_if.master fifo,
  output logic                     o_va,
  output logic                     o_vb,
  output logic                     o_vcom,
  output logic                     o_gsp,
  output logic                     o_gck,
  output logic                     o_gen,
  output logic                     o_intb,
  output logic                     o_bsp,
  output logic                     o_bck,
  output logic [RgbW-1:0]          o_rgb
);

  localparam int unsigned PreW  = $clog2(CLK_DIV);
  localparam int unsigned PixW  = $clog2(H_ACTIVE + 1);
  localparam int unsigned LineW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int unsigned GenW  = (GEN_TICKS > 1) ? $clog2(GEN_TICKS) : 1;

  localparam logic [PreW-1:0]  PreLast  = PreW'(CLK_DIV - 1);
  localparam logic [PreW-1:0]  PreHalf  = PreW'(CLK_DIV / 2 - 1);
  localparam logic [PixW-1:0]  PixLast  = PixW'(H_ACTIVE - 1);
  localparam logic [LineW-1:0] LineLast = LineW'(V_LINES - 1);
  localparam logic [GenW-1:0]  GenLast  = GenW'(GEN_TICKS - 1);

  seq_state_e state_q, state_d;

  logic [PreW-1:0]  pre_q, pre_d;
  logic [PixW-1:0]  pix_q, pix_d;
  logic [LineW-1:0] line_q, line_d;
  logic [GenW-1:0]  gen_cnt_q, gen_cnt_d;
  logic [RgbW-1:0]  rgb_q, rgb_d;
  logic gsp_q, gsp_d, gck_q, gck_d, gen_q, gen_d, bsp_q, bsp_d;
  logic bck_q, bck_d, bck_pend_q, bck_pend_d;
  logic underrun_q, underrun_d, done_q, done_d;

  logic tick_due, empty_due, stall, tick, pop;

  assign tick_due  = (state_q != StIdle) && (pre_q == PreLast);
  assign empty_due = (state_q == StShift) && tick_due && fifo.rempty;
`ifdef MEMLCD_UNDERRUN_BLANK_EN
  assign stall = 1'b0;
`else
  assign stall = empty_due;
`endif
  assign tick = tick_due && !stall;
  assign pop  = (state_q == StShift) && tick_due && !fifo.rempty;

  // Pop is gated by reset so an aborted frame never consumes another word.
  assign fifo.rd_en = pop && !i_reset;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM next-state logic; every transition except start waits for a tick.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (i_start) state_d = StGstart;
      StGstart:   if (tick) state_d = StShift;
      StShift:    if (tick && (pix_q == PixLast)) state_d = StGen;
      StGen:      if (tick && (gen_cnt_q == GenLast)) begin
                    state_d = (line_q == LineLast) ? StFrameEnd : StShift;
                  end
      StFrameEnd: if (tick) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // FSM output logic: next values of the prescaler, counters and panel pins.
  always_comb begin
    pre_d      = pre_q;
    pix_d      = pix_q;
    line_d     = line_q;
    gen_cnt_d  = gen_cnt_q;
    rgb_d      = rgb_q;
    gsp_d      = gsp_q;
    gck_d      = gck_q;
    gen_d      = gen_q;
    bsp_d      = bsp_q;
    bck_d      = bck_q;
    bck_pend_d = bck_pend_q;
    underrun_d = underrun_q;
    done_d     = 1'b0;

    // Stalled ticks hold the prescaler at its terminal count.
    if (state_q == StIdle)  pre_d = '0;
    else if (!stall)        pre_d = (pre_q == PreLast) ? '0 : pre_q + 1'b1;

    // BCK edge lands half a tick after each load so RGB has setup time.
    if (bck_pend_q && (pre_q == PreHalf)) begin
      bck_d      = ~bck_q;
      bck_pend_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          gsp_d      = 1'b1;
          underrun_d = 1'b0;
          pix_d      = '0;
          line_d     = '0;
          gen_cnt_d  = '0;
          bck_pend_d = 1'b0;
        end
      end
      StGstart: begin
        if (tick) begin
          gsp_d  = 1'b0;
          gck_d  = ~gck_q;
          line_d = '0;
          pix_d  = '0;
        end
      end
      StShift: begin
        if (empty_due) underrun_d = 1'b1;
        if (tick) begin
          // Only reachable empty when blanking is built in.
          rgb_d      = fifo.rempty ? '0 : fifo.rd_data;
          bsp_d      = (pix_q == '0);
          pix_d      = pix_q + 1'b1;
          bck_pend_d = 1'b1;
          if (pix_q == PixLast) begin
            gen_d     = 1'b1;
            gen_cnt_d = '0;
          end
        end
      end
      StGen: begin
        if (tick) begin
          bsp_d = 1'b0;
          rgb_d = '0;
          if (gen_cnt_q == GenLast) begin
            gen_d     = 1'b0;
            gen_cnt_d = '0;
            if (line_q != LineLast) begin
              line_d = line_q + 1'b1;
              gck_d  = ~gck_q;
              pix_d  = '0;
            end
          end else begin
            gen_cnt_d = gen_cnt_q + 1'b1;
          end
        end
      end
      StFrameEnd: begin
        if (tick) begin
          gck_d  = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered panel outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pre_q      <= '0;
      pix_q      <= '0;
      line_q     <= '0;
      gen_cnt_q  <= '0;
      rgb_q      <= '0;
      gsp_q      <= 1'b0;
      gck_q      <= 1'b0;
      gen_q      <= 1'b0;
      bsp_q      <= 1'b0;
      bck_q      <= 1'b0;
      bck_pend_q <= 1'b0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      pix_q      <= pix_d;
      line_q     <= line_d;
      gen_cnt_q  <= gen_cnt_d;
      rgb_q      <= rgb_d;
      gsp_q      <= gsp_d;
      gck_q      <= gck_d;
      gen_q      <= gen_d;
      bsp_q      <= bsp_d;
      bck_q      <= bck_d;
      bck_pend_q <= bck_pend_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
    end
  end

  assign o_busy       = (state_q != StIdle);
  assign o_intb       = (state_q != StIdle);
  assign o_frame_done = done_q;
  assign o_underrun   = underrun_q;
  assign o_gsp        = gsp_q;
  assign o_gck        = gck_q;
  assign o_gen        = gen_q;
  assign o_bsp        = bsp_q;
  assign o_bck        = bck_q;
  assign o_rgb        = rgb_q;

  memlcd_vcom_gen #(
    .VCOM_HALF (VCOM_HALF)
  ) u_vcom_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_va    (o_va),
    .o_vb    (o_vb),
    .o_vcom  (o_vcom)
  );

endmodule

// File: tb/tb_memlcd_frame_sequencer.sv
// Directed bench for memlcd_frame_sequencer (H_ACTIVE=4, V_LINES=2, CLK_DIV=2,
// GEN_TICKS=2, VCOM_HALF=8). Expectations for the blanking build follow
// MEMLCD_UNDERRUN_BLANK_EN.
module tb_memlcd_frame_sequencer;

  logic       clk = 1'b0;
  logic       i_reset, i_start;
  logic       o_busy, o_frame_done, o_underrun;
  logic       o_va, o_vb, o_vcom, o_gsp, o_gck, o_gen, o_intb, o_bsp, o_bck;
  logic [5:0] o_rgb;

  int vectors = 0;
  int miscompares = 0;

  memlcd_frame_sequencer_if fifo_if ();

  // FWFT FIFO model: pushes from the stimulus block, pops on DUT rd_en.
  logic [5:0] fmem [16];
  int head = 0;
  int tail = 0;
  assign fifo_if.rempty  = (head == tail);
  assign fifo_if.rd_data = fmem[head[3:0]];

  int pop_cnt = 0;
  always @(posedge clk) if (fifo_if.rd_en) begin
    head    <= head + 1;
    pop_cnt <= pop_cnt + 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always #5 clk = ~clk;

  memlcd_frame_sequencer #(
    .H_ACTIVE  (4),
    .V_LINES   (2),
    .CLK_DIV   (2),
    .GEN_TICKS (2),
    .VCOM_HALF (8)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_underrun   (o_underrun),
    .fifo         (fifo_if),
    .o_va         (o_va),
    .o_vb         (o_vb),
    .o_vcom       (o_vcom),
    .o_gsp        (o_gsp),
    .o_gck        (o_gck),
    .o_gen        (o_gen),
    .o_intb       (o_intb),
    .o_bsp        (o_bsp),
    .o_bck        (o_bck),
    .o_rgb        (o_rgb)
  );

  // Panel activity monitors, sampled mid-cycle.
  logic [5:0] rgb_log [64];
  int bck_tog = 0, gck_tog = 0, bsp_rise = 0, gen_hi = 0, gen_rise = 0, gsp_hi = 0;
  int done_cnt = 0, done_cyc = 0;
  logic bck_prev = 1'b0, gck_prev = 1'b0, bsp_prev = 1'b0, gen_prev = 1'b0;
  always @(negedge clk) begin
    if (o_bck != bck_prev) begin
      rgb_log[bck_tog % 64] <= o_rgb;
      bck_tog <= bck_tog + 1;
    end
    if (o_gck != gck_prev) gck_tog <= gck_tog + 1;
    if (o_bsp && !bsp_prev) bsp_rise <= bsp_rise + 1;
    if (o_gen && !gen_prev) gen_rise <= gen_rise + 1;
    if (o_gen) gen_hi <= gen_hi + 1;
    if (o_gsp) gsp_hi <= gsp_hi + 1;
    if (o_frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    bck_prev <= o_bck;
    gck_prev <= o_gck;
    bsp_prev <= o_bsp;
    gen_prev <= o_gen;
  end

`ifdef MEMLCD_UNDERRUN_BLANK_EN
  int t3_lat = 28;
  int t3_pops = 6;
  int t3_rgb [8] = '{1, 2, 0, 0, 3, 4, 5, 6};
`else
  int t3_lat = 31;
  int t3_pops = 8;
  int t3_rgb [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
`endif

  int start_cyc = 0;
  int b_pop, b_bck, b_gck, b_bsp, b_gen, b_genr, b_gsp, b_done;
  int lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] v);
    fmem[tail % 16] = v;
    tail = tail + 1;
  endtask

  task automatic preload(input int n);
    for (int i = 1; i <= n; i++) push(6'(i));
  endtask

  task automatic snap();
    b_pop = pop_cnt; b_bck = bck_tog; b_gck = gck_tog; b_bsp = bsp_rise;
    b_gen = gen_hi;  b_genr = gen_rise; b_gsp = gsp_hi; b_done = done_cnt;
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, output int l);
    int d0;
    d0 = done_cnt;
    l = -1;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (done_cnt != d0) begin
        l = done_cyc - start_cyc;
        break;
      end
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    step(3);

    // Reset state: everything low except VB.
    check("rst_ctrl", {o_busy, o_frame_done, o_underrun, fifo_if.rd_en}, 0);
    check("rst_panel", {o_gsp, o_gck, o_gen, o_intb, o_bsp, o_bck, o_rgb}, 0);
    check("rst_pol", {o_va, o_vb, o_vcom}, 3'b010);

    // VCOM runs in idle and flips every 8 cycles after reset release.
    i_reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      check("vcom", o_vcom, 32'((k / 8) % 2));
      check("va_vb", {o_va, o_vb}, {o_vcom, ~o_vcom});
    end

    // Nominal frame: 8 pops in order, exact timing and pin activity.
    preload(8);
    snap();
    start_frame();
    check("t1_busy", {o_busy, o_intb, o_gsp}, 3'b111);
    wait_done(60, lat);
    check("t1_latency", lat, 28);
    check("t1_pops", pop_cnt - b_pop, 8);
    for (int i = 0; i < 8; i++) check("t1_rgb", rgb_log[(b_bck + i) % 64], i + 1);
    check("t1_underrun", o_underrun, 0);
    check("t1_idle", {o_busy, o_intb, o_gck, o_rgb}, 0);
    check("t2_gsp_cycles", gsp_hi - b_gsp, 2);
    check("t2_gck_toggles", gck_tog - b_gck, 2);
    check("t2_bsp_pulses", bsp_rise - b_bsp, 2);
    check("t2_bck_toggles", bck_tog - b_bck, 8);
    check("t2_gen_cycles", gen_hi - b_gen, 8);
    check("t2_gen_pulses", gen_rise - b_genr, 2);

    // Underrun: two words ready, six more ten cycles after start.
    preload(2);
    snap();
    start_frame();
    step(10);
    for (int i = 3; i <= 8; i++) push(6'(i));
    wait_done(60, lat);
    check("t3_latency", lat, t3_lat);
    check("t3_underrun", o_underrun, 1);
    check("t3_pops", pop_cnt - b_pop, t3_pops);
    for (int i = 0; i < 8; i++) check("t3_rgb", rgb_log[(b_bck + i) % 64], t3_rgb[i]);
    tail = head;

    // Start while busy is ignored; underrun clears on the accepted start.
    preload(8);
    snap();
    start_frame();
    check("t5_underrun_clr", o_underrun, 0);
    step(9);
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
    wait_done(60, lat);
    check("t5_latency", lat, 28);
    step(40);
    check("t5_done_count", done_cnt - b_done, 1);
    check("t5_pops", pop_cnt - b_pop, 8);
    check("t5_idle", o_busy, 0);

    // Reset mid-SHIFT aborts the frame with no further pops.
    preload(8);
    snap();
    start_frame();
    step(7);
    check("t4_pre_pops", pop_cnt - b_pop, 2);
    check("t4_pre_busy", {o_busy, o_gck}, 2'b11);
    i_reset = 1'b1;
    step(1);
    check("t4_panel", {o_gsp, o_gck, o_gen, o_intb, o_bsp, o_bck, o_rgb}, 0);
    check("t4_busy", {o_busy, fifo_if.rd_en}, 0);
    i_reset = 1'b0;
    step(40);
    check("t4_post_pops", pop_cnt - b_pop, 2);
    check("t4_no_done", done_cnt - b_done, 0);
    tail = head;

    // Reset wins over a simultaneous start.
    preload(8);
    snap();
    i_reset = 1'b1;
    i_start = 1'b1;
    step(1);
    i_reset = 1'b0;
    i_start = 1'b0;
    check("rst_vs_start", {o_busy, o_gsp}, 0);
    step(5);
    check("rst_vs_start_pops", pop_cnt - b_pop, 0);
    tail = head;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
